// File: rtl/cpu_cond_pkg.sv
// Shared definitions for branch condition evaluation.
//   cond_e  : 3-bit condition codes (AL..LT) as presented on the cond port
//   state_e : state encoding of the branch_cond_eval controller
//   SVZ_*   : bit positions of N, V, Z inside the svz flag vector
package cpu_cond_pkg;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_MI = 3'b011,
    COND_PL = 3'b100,
    COND_VS = 3'b101,
    COND_VC = 3'b110,
    COND_LT = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int SVZ_N = 2;
  localparam int SVZ_V = 1;
  localparam int SVZ_Z = 0;

endpackage

// File: rtl/cond_decode.sv
// Combinational condition-code evaluator.
//   cond : condition code (cpu_cond_pkg::cond_e encoding)
//   svz  : flag vector, [2]=N [1]=V [0]=Z
//   pass : 1 when the condition holds for the given flags
module cond_decode
  import cpu_cond_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] svz,
  output logic       pass
);

  logic flag_n;
  logic flag_v;
  logic flag_z;

  assign flag_n = svz[SVZ_N];
  assign flag_v = svz[SVZ_V];
  assign flag_z = svz[SVZ_Z];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = flag_z;
      COND_NE: pass = ~flag_z;
      COND_MI: pass = flag_n;
      COND_PL: pass = ~flag_n;
      COND_VS: pass = flag_v;
      COND_VC: pass = ~flag_v;
      COND_LT: pass = flag_n ^ flag_v;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator with flag-update interlock.
// Accepts one condition code at a time, evaluates it against the status
// flags once they are stable (or after MAX_WAIT cycles of pending updates),
// and holds the result until the consumer takes it.
//   clk, rst            : clock, async active-high reset
//   svz, flag_update    : status flags and "flags change next edge" hint
//   req_valid/ready,cond: request handshake and condition code
//   resp_valid/ready    : response handshake
//   taken, timeout      : result and "forced by wait limit" flag
//   taken_cnt           : saturating count of accepted taken responses
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, waiting for pending flag update to settle
// RESP  | result registered, waiting for resp_ready
module branch_cond_eval
  import cpu_cond_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       svz,
  input  logic             flag_update,
  input  logic             req_valid,
  input  logic [2:0]       cond,
  output logic             req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic             timeout,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_e           state, state_n;
  logic [3:0]       wait_cnt, wait_n, wait_inc;
  logic [2:0]       cond_q, cond_n;
  logic             taken_q, taken_n;
  logic             timeout_q, timeout_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       eval_cond;
  logic             pass;

  // In IDLE the incoming code is evaluated directly so the no-wait path
  // has single-cycle latency; otherwise the latched code is used.
  assign eval_cond = (state == ST_IDLE) ? cond : cond_q;
  assign wait_inc  = wait_cnt + 4'd1;

  cond_decode u_cond_decode (
    .cond (eval_cond),
    .svz  (svz),
    .pass (pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      cond_q    <= 3'b000;
      taken_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      cond_q    <= cond_n;
      taken_q   <= taken_n;
      timeout_q <= timeout_n;
      cnt_q     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    cond_n    = cond_q;
    taken_n   = taken_q;
    timeout_n = timeout_q;
    cnt_n     = cnt_q;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          cond_n = cond;
          if (flag_update) begin
            wait_n  = 4'd0;
            state_n = ST_WAIT;
          end else begin
            taken_n   = pass;
            timeout_n = 1'b0;
            state_n   = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!flag_update) begin
          taken_n   = pass;
          timeout_n = 1'b0;
          state_n   = ST_RESP;
        end else if (wait_inc == WAIT_LIMIT) begin
          // Flags still churning at the limit: evaluate what we have.
          wait_n    = wait_inc;
          taken_n   = pass;
          timeout_n = 1'b1;
          state_n   = ST_RESP;
        end else begin
          wait_n = wait_inc;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_n = ST_IDLE;
          if (taken_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign taken      = taken_q;
  assign timeout    = timeout_q;
  assign taken_cnt  = cnt_q;

endmodule

// File: tb/tb_branch_cond_eval.sv
module tb_branch_cond_eval;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [2:0]       svz;
  logic             flag_update;
  logic             req_valid;
  logic [2:0]       cond;
  logic             req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic             taken;
  logic             timeout;
  logic [CNT_W-1:0] taken_cnt;

  int total = 0;
  int bad   = 0;

  // expected {taken, timeout} per response, in order
  logic [1:0] exp_q[$];

  branch_cond_eval #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .svz         (svz),
    .flag_update (flag_update),
    .req_valid   (req_valid),
    .cond        (cond),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .taken       (taken),
    .timeout     (timeout),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a response is consumed at the next edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got taken=%0b timeout=%0b expected no response", taken, timeout);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({taken, timeout} !== e) begin
          bad++;
          $display("FAIL resp_data: got taken/timeout=%0b%0b expected %0b%0b", taken, timeout, e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Expected results for all eight codes, indexed by cond.
  logic exp_a[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}; // svz=101
  logic exp_b[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // svz=010

  initial begin
    rst = 1'b1; svz = 3'b000; flag_update = 1'b0;
    req_valid = 1'b0; cond = 3'b000; resp_ready = 1'b0;
    #12 rst = 1'b0;
    #1;
    chk("rst_req_ready", 8'(req_ready), 8'd1);
    chk("rst_resp_valid", 8'(resp_valid), 8'd0);
    chk("rst_taken", 8'(taken), 8'd0);
    chk("rst_timeout", 8'(timeout), 8'd0);
    chk("rst_cnt", 8'(taken_cnt), 8'd0);

    // EQ on Z=1, latency 1
    tick();
    svz = 3'b001; flag_update = 1'b0; cond = 3'b001; req_valid = 1'b1; resp_ready = 1'b1;
    exp_q.push_back(2'b10);
    tick();
    req_valid = 1'b0;
    chk("eq_latency_valid", 8'(resp_valid), 8'd1);
    tick();
    chk("eq_cnt", 8'(taken_cnt), 8'd1);
    chk("eq_ready_back", 8'(req_ready), 8'd1);

    // LT with two cycles of pending update, flags settle to 110
    svz = 3'b100; flag_update = 1'b1; cond = 3'b111; req_valid = 1'b1; resp_ready = 1'b1;
    exp_q.push_back(2'b00);
    tick();
    req_valid = 1'b0;
    chk("lt_in_wait", 8'(req_ready), 8'd0);
    tick();
    svz = 3'b110; flag_update = 1'b0;
    chk("lt_wait_no_resp", 8'(resp_valid), 8'd0);
    tick();
    chk("lt_resp_valid", 8'(resp_valid), 8'd1);
    tick();
    chk("lt_cnt", 8'(taken_cnt), 8'd1);

    // VS with flag_update stuck high: timeout after 4 WAIT cycles
    svz = 3'b010; flag_update = 1'b1; cond = 3'b101; req_valid = 1'b1; resp_ready = 1'b1;
    exp_q.push_back(2'b11);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("vs_still_waiting", 8'(resp_valid), 8'd0);
    end
    tick();
    chk("vs_timeout_valid", 8'(resp_valid), 8'd1);
    flag_update = 1'b0;
    tick();
    chk("vs_cnt", 8'(taken_cnt), 8'd2);

    // Backpressure: result stable while svz toggles, extra request ignored
    svz = 3'b001; cond = 3'b001; req_valid = 1'b1; resp_ready = 1'b0;
    exp_q.push_back(2'b10);
    tick();
    cond = 3'b000;
    for (int i = 0; i < 3; i++) begin
      svz = (i == 1) ? 3'b111 : 3'b000;
      tick();
      chk("bp_valid", 8'(resp_valid), 8'd1);
      chk("bp_taken", 8'(taken), 8'd1);
      chk("bp_timeout", 8'(timeout), 8'd0);
      chk("bp_req_ready", 8'(req_ready), 8'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    tick();
    chk("bp_cnt", 8'(taken_cnt), 8'd3);
    tick();
    chk("bp_no_extra", 8'(resp_valid), 8'd0);

    // Saturation: one more taken AL keeps cnt at 3
    cond = 3'b000; req_valid = 1'b1;
    exp_q.push_back(2'b10);
    tick();
    req_valid = 1'b0;
    tick();
    chk("sat_cnt", 8'(taken_cnt), 8'd3);

    // Full decode table on two flag patterns
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 8; c++) begin
        svz = (p == 0) ? 3'b101 : 3'b010;
        cond = 3'(c); req_valid = 1'b1; flag_update = 1'b0; resp_ready = 1'b1;
        exp_q.push_back({(p == 0) ? exp_a[c] : exp_b[c], 1'b0});
        tick();
        req_valid = 1'b0;
        tick();
      end
    end

    // Async reset while in WAIT
    svz = 3'b001; flag_update = 1'b1; cond = 3'b000; req_valid = 1'b1; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_valid", 8'(resp_valid), 8'd0);
    chk("rst_wait_cnt", 8'(taken_cnt), 8'd0);
    chk("rst_wait_ready", 8'(req_ready), 8'd1);
    tick();
    chk("rst_held_ready", 8'(req_ready), 8'd1);
    rst = 1'b0; flag_update = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_stale", 8'(resp_valid), 8'd0);
    end

    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_cond_eval.md
BRANCH_COND_EVAL -- requirements
Module: branch_cond_eval

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: cycles to wait for a pending flag update before forcing evaluation (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8: width of the taken-branch counter.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port svz, input, 3: current flag vector from the status register; [2]=N, [1]=V, [0]=Z.
REQ-006 SHALL have port flag_update, input, 1: high means svz changes at the next clk edge.
REQ-007 SHALL have port req_valid, input, 1: evaluation request present.
REQ-008 SHALL have port cond, input, 3: condition code, qualified by req_valid.
REQ-009 SHALL have port req_ready, output, 1: block can accept a request.
REQ-010 SHALL have port resp_valid, output, 1: response present.
REQ-011 SHALL have port resp_ready, input, 1: consumer accepts the response.
REQ-012 SHALL have port taken, output, 1: condition result, qualified by resp_valid.
REQ-013 SHALL have port timeout, output, 1: result forced by wait limit, qualified by resp_valid.
REQ-014 SHALL have port taken_cnt, output, CNT_W: saturating count of accepted taken responses.

Function
REQ-015 SHALL decode cond as: 000 AL=1, 001 EQ=Z, 010 NE=!Z, 011 MI=N, 100 PL=!N, 101 VS=V, 110 VC=!V, 111 LT=N^V.
REQ-016 SHALL implement states IDLE, WAIT, RESP; req_ready = (state==IDLE).
REQ-017 SHALL accept a request when req_valid && req_ready, latching cond.
REQ-018 At acceptance with flag_update=0, SHALL evaluate cond on current svz, register taken, timeout=0, and enter RESP (resp_valid at the next cycle, latency 1).
REQ-019 At acceptance with flag_update=1, SHALL enter WAIT with wait counter cleared.
REQ-020 In WAIT with flag_update=0, SHALL evaluate latched cond on current svz, register result, timeout=0, and enter RESP.
REQ-021 In WAIT with flag_update=1, SHALL increment the wait counter; when it reaches MAX_WAIT, SHALL evaluate on current svz, set timeout=1, and enter RESP.
REQ-022 In RESP, resp_valid SHALL be 1 and taken/timeout held stable until resp_ready=1.
REQ-023 On resp_valid && resp_ready, SHALL return to IDLE; no request is accepted in that same cycle (one bubble).
REQ-024 On resp_valid && resp_ready && taken, taken_cnt SHALL increment, saturating at all ones (no wrap).
REQ-025 Requests presented while req_ready=0 SHALL be ignored, not queued.
REQ-026 svz SHALL be sampled only in the evaluation cycle; changes in RESP SHALL NOT alter taken.

Reset
REQ-027 On rst assertion, SHALL immediately set state=IDLE, resp_valid=0, taken=0, timeout=0, taken_cnt=0, wait counter=0, latched cond=000, independent of clk.
REQ-028 Reset mid-WAIT or mid-RESP SHALL discard the pending request without a response; req_ready=1 while rst is held and after release.

Structure
REQ-029 SHALL place condition-code constants (AL..LT) and the state encoding in shared package cpu_cond_pkg.
REQ-030 SHALL instantiate one combinational sub-module cond_decode (inputs cond, svz; output pass) used for all evaluations.

Verification
REQ-031 svz=001, flag_update=0, req cond=001 at cycle T -> resp_valid=1 at T+1, taken=1, timeout=0; taken_cnt 0->1 on handshake.
REQ-032 svz=100, req cond=111 with flag_update=1 for 2 cycles, svz becomes 110 after -> WAIT, evaluated on 110, taken=0, timeout=0.
REQ-033 flag_update held high, MAX_WAIT=4, svz=010, cond=101 -> resp_valid after 4 WAIT cycles, taken=1, timeout=1.
REQ-034 resp_ready held 0 for 3 cycles while svz toggles -> resp_valid and taken stable; req_ready=0 and a second request is ignored.
REQ-035 CNT_W=2, four taken AL handshakes -> taken_cnt = 3 (saturated).
REQ-036 rst pulsed asynchronously in WAIT -> resp_valid=0, taken_cnt=0, req_ready=1 immediately; no stale response after release.
